// File: rtl/idli_cmp_m.sv
// idli_cmp_m: bit-serial 16-bit compare unit feeding the predicate file's Q write port.
// Operands arrive LSB first, one bit per cycle; the result is written one cycle after bit 15.
// Optional feature macro: IDLI_CMP_INV_EN (latched result inversion giving NE/GE/GEU forms).
module idli_cmp_m (
    input  logic       i_cmp_gck,
    input  logic       i_cmp_rst_n,
    input  logic       i_cmp_start,
    input  logic [1:0] i_cmp_op,
    input  logic [1:0] i_cmp_preg,
    input  logic       i_cmp_inv,
    input  logic       i_cmp_a,
    input  logic       i_cmp_b,
    output logic       o_cmp_busy,
    output logic       o_cmp_wr_en,
    output logic [1:0] o_cmp_preg,
    output logic       o_cmp_data
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned PREG_W = 2;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(15);
    localparam logic [PREG_W-1:0] PREG_TRUE = PREG_W'(3);

    localparam logic [OP_W-1:0] OP_EQ  = 2'd0;
    localparam logic [OP_W-1:0] OP_LT  = 2'd1;
    localparam logic [OP_W-1:0] OP_LTU = 2'd2;
    localparam logic [OP_W-1:0] OP_TST = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [OP_W-1:0]   op_q;
    logic [PREG_W-1:0] preg_q;
    logic              eq_q;
    logic              ltu_q;
    logic              any_q;

    logic              start_ok_c;
    logic              last_c;
    logic              bit_eq_c;
    logic              bit_lt_c;
    logic              raw_c;
    logic              result_c;

    // Start is only honoured when no operation is in flight.
    assign start_ok_c = i_cmp_start && ((state_q == ST_IDLE) || (state_q == ST_WB));
    assign last_c     = (state_q == ST_RUN) && (cnt_q == LAST_BIT);
    assign bit_eq_c   = ~(i_cmp_a ^ i_cmp_b);
    assign bit_lt_c   = ~i_cmp_a & i_cmp_b;

    // State register.
    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_cmp_start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST_BIT) state_d = ST_WB;
            ST_WB:   state_d = i_cmp_start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Final-bit result: bit 15 is folded in here rather than through the accumulators.
    always_comb begin
        raw_c = 1'b0;
        case (op_q)
            OP_EQ:   raw_c = eq_q & bit_eq_c;
            OP_LT:   raw_c = bit_eq_c ? ltu_q : i_cmp_a;
            OP_LTU:  raw_c = bit_eq_c ? ltu_q : bit_lt_c;
            OP_TST:  raw_c = any_q | (i_cmp_a & i_cmp_b);
            default: raw_c = 1'b0;
        endcase
    end

`ifdef IDLI_CMP_INV_EN
    logic inv_q;

    // Inversion flag captured with the rest of the command.
    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            inv_q <= 1'b0;
        end else if (start_ok_c) begin
            inv_q <= i_cmp_inv;
        end
    end

    assign result_c = raw_c ^ inv_q;
`else
    logic unused_inv;
    assign unused_inv = i_cmp_inv;
    assign result_c   = raw_c;
`endif

    // Command capture, bit counter and serial accumulators.
    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            cnt_q  <= '0;
            op_q   <= '0;
            preg_q <= '0;
            eq_q   <= 1'b0;
            ltu_q  <= 1'b0;
            any_q  <= 1'b0;
        end else if (start_ok_c) begin
            cnt_q  <= CNT_W'(1);
            op_q   <= i_cmp_op;
            preg_q <= i_cmp_preg;
            eq_q   <= bit_eq_c;
            ltu_q  <= bit_lt_c;
            any_q  <= i_cmp_a & i_cmp_b;
        end else if (state_q == ST_RUN) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            eq_q   <= eq_q & bit_eq_c;
            ltu_q  <= bit_eq_c ? ltu_q : bit_lt_c;
            any_q  <= any_q | (i_cmp_a & i_cmp_b);
        end
    end

    // Registered outputs; index and data hold between writes.
    always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
        if (!i_cmp_rst_n) begin
            o_cmp_busy  <= 1'b0;
            o_cmp_wr_en <= 1'b0;
            o_cmp_preg  <= '0;
            o_cmp_data  <= 1'b0;
        end else begin
            o_cmp_busy  <= (state_d == ST_RUN);
            o_cmp_wr_en <= last_c && (preg_q != PREG_TRUE);
            if (last_c) begin
                o_cmp_preg <= preg_q;
                o_cmp_data <= result_c;
            end
        end
    end

endmodule

// File: tb/tb_idli_cmp_m.sv
// Scoreboard bench for idli_cmp_m: directed operations push expected writes,
// an independent monitor checks every write strobe against the queue.
module tb_idli_cmp_m;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op_in;
    logic [1:0] preg_in;
    logic       inv_in;
    logic       a_in;
    logic       b_in;
    logic       busy;
    logic       wr_en;
    logic [1:0] preg_out;
    logic       data_out;

    typedef struct {
        int         cyc;
        logic [1:0] preg;
        logic       data;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [1:0] EQ  = 2'd0;
    localparam logic [1:0] LT  = 2'd1;
    localparam logic [1:0] LTU = 2'd2;
    localparam logic [1:0] TST = 2'd3;

    idli_cmp_m dut (
        .i_cmp_gck   (clk),
        .i_cmp_rst_n (rst_n),
        .i_cmp_start (start),
        .i_cmp_op    (op_in),
        .i_cmp_preg  (preg_in),
        .i_cmp_inv   (inv_in),
        .i_cmp_a     (a_in),
        .i_cmp_b     (b_in),
        .o_cmp_busy  (busy),
        .o_cmp_wr_en (wr_en),
        .o_cmp_preg  (preg_out),
        .o_cmp_data  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wr_en) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write cyc=%0d preg=%0d data=%0d required=no write",
                         cyc, preg_out, data_out);
            end else begin
                e = sb_q.pop_front();
                if (cyc != e.cyc || preg_out !== e.preg || data_out !== e.data) begin
                    n_fail++;
                    $display("FAIL write cyc=%0d preg=%0d data=%0d required cyc=%0d preg=%0d data=%0d",
                             cyc, preg_out, data_out, e.cyc, e.preg, e.data);
                end
            end
        end
    end

    // Serial operation; extra_k issues an ignored start with scrambled command fields,
    // abort_k pulls reset in that cycle.
    task automatic send(input logic [1:0] op, input logic [1:0] preg, input logic inv,
                        input logic [15:0] a, input logic [15:0] b, input logic exp_data,
                        input int extra_k, input int abort_k);
        int s = 0;
        bit aborted = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_k) begin
                rst_n = 1'b0;
                start = 1'b0;
                #1;
                chk("abort_busy",  busy,     0);
                chk("abort_wr_en", wr_en,    0);
                chk("abort_preg",  preg_out, 0);
                chk("abort_data",  data_out, 0);
                aborted = 1;
                break;
            end
            start = (k == 0) || (k == extra_k);
            op_in   = (k == extra_k) ? ~op   : op;
            preg_in = (k == extra_k) ? ~preg : preg;
            inv_in  = (k == extra_k) ? ~inv  : inv;
            a_in = a[k];
            b_in = b[k];
            if (k == 0) s = cyc;
            chk("busy", busy, (k != 0));
        end
        if (!aborted && preg != 2'd3) sb_q.push_back('{s + 16, preg, exp_data});
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        logic inv_exp;
`ifdef IDLI_CMP_INV_EN
        inv_exp = 1'b1;
`else
        inv_exp = 1'b0;
`endif
        rst_n = 1'b0; start = 1'b0; op_in = '0; preg_in = '0;
        inv_in = 1'b0; a_in = 1'b0; b_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  busy,     0);
        chk("rst_wr_en", wr_en,    0);
        chk("rst_preg",  preg_out, 0);
        chk("rst_data",  data_out, 0);
        rst_n = 1'b1;
        idle(2);

        send(EQ,  2'd1, 1'b0, 16'h1234, 16'h1234, 1'b1, -1, -1); idle(4);
        send(EQ,  2'd1, 1'b0, 16'h1234, 16'h1235, 1'b0, -1, -1); idle(4);
        send(LT,  2'd2, 1'b0, 16'h8000, 16'h0001, 1'b1, -1, -1); idle(4);
        send(LTU, 2'd2, 1'b0, 16'h8000, 16'h0001, 1'b0, -1, -1); idle(4);
        send(LT,  2'd2, 1'b0, 16'h7FFF, 16'hFFFF, 1'b0, -1, -1); idle(4);
        send(TST, 2'd0, 1'b0, 16'h00F0, 16'h0F00, 1'b0, -1, -1); idle(4);
        send(TST, 2'd0, 1'b0, 16'h0010, 16'h0030, 1'b1, -1, -1); idle(4);
        send(TST, 2'd1, 1'b1, 16'h00F0, 16'h0F00, inv_exp, -1, -1); idle(4);

        // Constant-true destination: never written.
        send(EQ, 2'd3, 1'b0, 16'hABCD, 16'hABCD, 1'b1, -1, -1);
        @(posedge clk); #1; start = 1'b0; chk("p3_wr_t16", wr_en, 0);
        @(posedge clk); #1;               chk("p3_wr_t17", wr_en, 0);
        idle(4);

        // Back-to-back with an ignored start at T+5.
        send(LTU, 2'd0, 1'b0, 16'h0001, 16'h8000, 1'b1, 5, -1);
        send(LT,  2'd2, 1'b0, 16'hFFFF, 16'h0000, 1'b1, -1, -1);
        idle(4);

        // Leave preg=2/data=1 on the outputs, then abort at T+8.
        send(LT, 2'd2, 1'b0, 16'h8000, 16'h0001, 1'b1, -1, -1); idle(4);
        send(EQ, 2'd1, 1'b0, 16'h5555, 16'h5555, 1'b1, -1, 8);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(25);
        #1;
        chk("post_abort_wr_en", wr_en, 0);
        chk("post_abort_busy",  busy,  0);
        send(EQ, 2'd1, 1'b0, 16'h5555, 16'h5555, 1'b1, -1, -1); idle(6);

        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
